io_seq_monitor: RTL and testbench

IO_SEQ_MONITOR -- requirements
Module: io_seq_monitor

---
 rtl/iomon_pkg.sv | 16 +
 rtl/io_seq_monitor_if.sv | 12 +
 rtl/iomon_fifo.sv | 54 +++++
 rtl/io_seq_monitor.sv | 129 ++++++++++++
 tb/tb_io_seq_monitor.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iomon_pkg.sv
// Shared types and default parameters for the IO sequence monitor.
package iomon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PASS    = 2'd2,
        ST_TIMEOUT = 2'd3
    } iomon_state_e;

    localparam int DEF_WIDTH      = 34;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_CHUNK      = 1000;
    localparam int DEF_MAX_CHUNKS = 100;

endpackage

// File: rtl/io_seq_monitor_if.sv
// Expected-pattern push channel into the IO sequence monitor.
interface io_seq_monitor_if #(
    parameter int WIDTH = iomon_pkg::DEF_WIDTH
);
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_last;
    logic             exp_ready;

    modport master (output exp_valid, exp_data, exp_last, input exp_ready);
    modport slave  (input exp_valid, exp_data, exp_last, output exp_ready);
endinterface

// File: rtl/iomon_fifo.sv
// Expected-pattern FIFO; entry MSB carries the last tag, flush empties it in one edge.
module iomon_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Gating on full means a push into a full FIFO is lost even if a pop frees a slot.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/io_seq_monitor.sv
// Watches an async IO bus for a queued sequence of masked patterns, with chunked timeout.
// Define IOMON_STABLE_FILTER_EN to require a compare to hold for two synchronized cycles.
module io_seq_monitor
    import iomon_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CHUNK      = DEF_CHUNK,
    parameter int MAX_CHUNKS = DEF_MAX_CHUNKS
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       check_bits,
    input  logic [WIDTH-1:0]       mask,
    io_seq_monitor_if.slave        exp_bus,
    output logic                   busy,
    output logic                   pass,
    output logic                   timeout,
    output logic                   chunk_tick,
    output logic [7:0]             match_count,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW  = $clog2(CHUNK + 1);
    localparam int KW  = $clog2(MAX_CHUNKS + 1);
    localparam logic [CW-1:0] CYC_LAST   = CW'(CHUNK - 1);
    localparam logic [KW-1:0] CHUNK_LAST = KW'(MAX_CHUNKS - 1);

    iomon_state_e     state_q, state_d;
    logic [WIDTH-1:0] sync_q1, sync_q2;
    logic [WIDTH:0]   head;
    logic             full, empty, flush, start;
    logic             cmp_ok, match, last_match, wrap, limit;
    logic [CW-1:0]    cyc_cnt;
    logic [KW-1:0]    chunk_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= check_bits;
            sync_q2 <= sync_q1;
        end
    end

    assign exp_bus.exp_ready = !full;
    assign flush = clear && (state_q == ST_PASS || state_q == ST_TIMEOUT);
    assign start = (state_q == ST_IDLE) && en;

    iomon_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .flush (flush),
        .push  (exp_bus.exp_valid),
        .din   ({exp_bus.exp_last, exp_bus.exp_data}),
        .pop   (match),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign cmp_ok = (state_q == ST_RUN) && !empty &&
                    (((sync_q2 ^ head[WIDTH-1:0]) & mask) == '0);

`ifdef IOMON_STABLE_FILTER_EN
    logic cmp_prev;
    // A pop restarts qualification so the next head needs its own two cycles.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cmp_prev <= 1'b0;
        else       cmp_prev <= cmp_ok && !match;
    end
    assign match = cmp_ok && cmp_prev;
`else
    assign match = cmp_ok;
`endif

    assign last_match = match && head[WIDTH];
    assign wrap       = (state_q == ST_RUN) && (cyc_cnt == CYC_LAST);
    assign limit      = wrap && (chunk_cnt == CHUNK_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (en) state_d = ST_RUN;
            ST_RUN: begin
                if (last_match) state_d = ST_PASS;
                else if (limit) state_d = ST_TIMEOUT;
                else if (!en)   state_d = ST_IDLE;
            end
            ST_PASS,
            ST_TIMEOUT: if (clear) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            chunk_tick  <= 1'b0;
            cyc_cnt     <= '0;
            chunk_cnt   <= '0;
            match_count <= '0;
        end else begin
            busy       <= (state_d == ST_RUN);
            pass       <= (state_d == ST_PASS);
            timeout    <= (state_d == ST_TIMEOUT);
            chunk_tick <= wrap;
            if (start) begin
                cyc_cnt     <= '0;
                chunk_cnt   <= '0;
                match_count <= '0;
            end else if (state_q == ST_RUN) begin
                cyc_cnt <= wrap ? '0 : cyc_cnt + CW'(1);
                if (wrap) chunk_cnt <= chunk_cnt + KW'(1);
                if (match && match_count != 8'hFF) match_count <= match_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_io_seq_monitor.sv
// Scoreboarded bench for io_seq_monitor: directed scenarios plus randomized sequences.
module tb_io_seq_monitor;
    localparam int W = 8, D = 4, CH = 10, MC = 4;
`ifdef IOMON_STABLE_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        bit is_pass;
        int mc;
        int fc;
    } outcome_t;

    logic       clk = 1'b0, nrst = 1'b0, en = 1'b0, clear = 1'b0;
    logic [7:0] check_bits = 8'h00, mask = 8'hFF;
    logic       busy, pass, timeout, chunk_tick;
    logic [7:0] match_count;
    logic [2:0] fifo_count;

    io_seq_monitor_if #(.WIDTH(W)) bus ();

    io_seq_monitor #(.WIDTH(W), .DEPTH(D), .CHUNK(CH), .MAX_CHUNKS(MC)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .clear       (clear),
        .check_bits  (check_bits),
        .mask        (mask),
        .exp_bus     (bus),
        .busy        (busy),
        .pass        (pass),
        .timeout     (timeout),
        .chunk_tick  (chunk_tick),
        .match_count (match_count),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int       n_tests = 0, n_fail = 0;
    int       mdl_cnt = 0;
    outcome_t sb_q[$];
    bit       mon_prev = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endfunction

    function automatic void sb_push(bit p, int m, int f);
        outcome_t o;
        o.is_pass = p; o.mc = m; o.fc = f;
        sb_q.push_back(o);
    endfunction

    // Monitor: every new terminal state is checked against the oldest expected outcome.
    initial begin
        outcome_t o;
        forever begin
            @(negedge clk);
            if ((pass || timeout) && !mon_prev) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_unexpected: terminal pass=%0b timeout=%0b with no expected outcome", pass, timeout);
                end else begin
                    o = sb_q.pop_front();
                    chk("sb_kind_pass", {31'd0, pass}, {31'd0, o.is_pass});
                    chk("sb_match_count", {24'd0, match_count}, o.mc);
                    chk("sb_fifo_count", {29'd0, fifo_count}, o.fc);
                end
            end
            mon_prev = pass || timeout;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push1(input logic [7:0] d, input bit l);
        @(negedge clk);
        chk("exp_ready", {31'd0, bus.exp_ready}, (mdl_cnt < D) ? 1 : 0);
        bus.exp_valid = 1'b1; bus.exp_data = d; bus.exp_last = l;
        if (mdl_cnt < D) mdl_cnt++;
    endtask

    task automatic push_done();
        @(negedge clk);
        bus.exp_valid = 1'b0; bus.exp_last = 1'b0;
        chk("fifo_count_after_push", {29'd0, fifo_count}, mdl_cnt);
    endtask

    task automatic drive(input logic [7:0] v, input int n);
        @(negedge clk);
        check_bits = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic start_run();
        @(negedge clk);
        en = 1'b1;
    endtask

    task automatic wait_term(input int budget);
        int k = 0;
        while (!(pass || timeout) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!(pass || timeout)) begin
            n_tests++; n_fail++;
            $display("FAIL wait_term: no pass/timeout within %0d cycles", budget);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        en = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_busy", {31'd0, busy}, 0);
        chk("clear_pass", {31'd0, pass}, 0);
        chk("clear_timeout", {31'd0, timeout}, 0);
        chk("clear_fifo_count", {29'd0, fifo_count}, 0);
        mdl_cnt = 0;
    endtask

    initial begin
        logic [7:0] ent[6];
        logic [7:0] mb, v;
        int kp, n, j;
        bit miss, last_acc;

        bus.exp_valid = 1'b0; bus.exp_data = '0; bus.exp_last = 1'b0;
        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pass", {31'd0, pass}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        chk("rst_tick", {31'd0, chunk_tick}, 0);
        chk("rst_match_count", {24'd0, match_count}, 0);
        chk("rst_fifo_count", {29'd0, fifo_count}, 0);
        @(negedge clk);
        nrst = 1'b1;
        chk("rst_exp_ready", {31'd0, bus.exp_ready}, 1);

        // Two-entry sequence with exact pass latency.
        push1(8'h11, 1'b0); push1(8'h22, 1'b1); push_done();
        start_run();
        drive(8'h11, 6);
        chk("seq_mc_after_first", {24'd0, match_count}, 1);
        chk("seq_fc_after_first", {29'd0, fifo_count}, 1);
        sb_push(1'b1, 2, 0);
        @(negedge clk);
        check_bits = 8'h22;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            chk("seq_pass_latency", {31'd0, pass}, (i == LAT) ? 1 : 0);
        end
        chk("seq_busy_after_pass", {31'd0, busy}, 0);
        chk("seq_mc_final", {24'd0, match_count}, 2);
        do_clear();

        // Never-matching entry: chunk ticks every CH cycles, timeout after MC chunks.
        check_bits = 8'h00;
        push1(8'h5A, 1'b1); push_done();
        sb_push(1'b0, 0, 1);
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k <= CH * MC; k++) begin
            @(negedge clk);
            chk("to_chunk_tick", {31'd0, chunk_tick}, (k > 0 && k % CH == 0) ? 1 : 0);
            chk("to_timeout", {31'd0, timeout}, (k == CH * MC) ? 1 : 0);
            chk("to_busy", {31'd0, busy}, (k < CH * MC) ? 1 : 0);
        end
        do_clear();

        // Masked compare ignores the upper nibble.
        mask = 8'h0F; check_bits = 8'h00;
        push1(8'h03, 1'b1); push_done();
        sb_push(1'b1, 1, 0);
        start_run();
        drive(8'hF3, 2);
        wait_term(10);
        do_clear();
        mask = 8'hFF;

        // Overfill: the fifth push is dropped and exp_ready drops after the fourth.
        check_bits = 8'h00;
        for (int i = 1; i <= 5; i++) push1(8'(i), (i >= 4));
        push_done();
        sb_push(1'b1, 4, 0);
        start_run();
        for (int i = 1; i <= 4; i++) drive(8'(i), 4);
        wait_term(20);
        do_clear();

        // Reset mid-run discards queued entries.
        check_bits = 8'h00;
        push1(8'h31, 1'b0); push1(8'h32, 1'b0); push1(8'h33, 1'b1); push_done();
        start_run();
        drive(8'h31, 6);
        chk("mid_mc_before_reset", {24'd0, match_count}, 1);
        chk("mid_fc_before_reset", {29'd0, fifo_count}, 2);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_mc", {24'd0, match_count}, 0);
        chk("mid_rst_fc", {29'd0, fifo_count}, 0);
        chk("mid_rst_ready", {31'd0, bus.exp_ready}, 1);
        en = 1'b0; mdl_cnt = 0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("mid_post_busy", {31'd0, busy}, 0);
        chk("mid_post_fc", {29'd0, fifo_count}, 0);

        // Single-cycle glitch on the bus.
        check_bits = 8'h00;
        push1(8'h11, 1'b1); push_done();
        start_run();
        repeat (3) @(negedge clk);
`ifdef IOMON_STABLE_FILTER_EN
        drive(8'h11, 1);
        drive(8'h00, 6);
        chk("glitch_ignored_mc", {24'd0, match_count}, 0);
        chk("glitch_ignored_busy", {31'd0, busy}, 1);
        chk("glitch_ignored_fc", {29'd0, fifo_count}, 1);
        sb_push(1'b1, 1, 0);
        drive(8'h11, 2);
        drive(8'h00, 4);
        chk("glitch_stable_pass", {31'd0, pass}, 1);
`else
        sb_push(1'b1, 1, 0);
        drive(8'h11, 1);
        drive(8'h00, 6);
        chk("glitch_match_pass", {31'd0, pass}, 1);
`endif
        do_clear();

        // Randomized sequences against a queue-level model.
        for (int it = 0; it < 30; it++) begin
            mask = 8'($urandom);
            mask[$urandom_range(7, 0)] = 1'b1;
            mb = mask & (~mask + 8'd1);
            kp = $urandom_range(6, 1);
            for (int i = 0; i < kp; i++) begin
                ent[i] = 8'($urandom);
                if (i > 0) while ((ent[i] & mask) == (ent[i-1] & mask)) ent[i] = 8'($urandom);
            end
            n = (kp < D) ? kp : D;
            last_acc = (kp <= D);
            miss = ($urandom_range(3, 0) == 0);
            j = $urandom_range(n - 1, 0);
            check_bits = ent[0] ^ mb;
            for (int i = 0; i < kp; i++) push1(ent[i], (i == kp - 1));
            push_done();
            if (miss)          sb_push(1'b0, j, n - j);
            else if (last_acc) sb_push(1'b1, n, 0);
            else               sb_push(1'b0, n, 0);
            start_run();
            for (int i = 0; i < (miss ? j : n); i++) begin
                v = (ent[i] & mask) | (8'($urandom) & ~mask);
                drive(v, 6);
            end
            if (miss) drive(ent[j] ^ mb, 1);
            wait_term(80);
            do_clear();
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
